dev_bus_arbiter: RTL and testbench
==================================

DEV_BUS_ARBITER -- requirements
Module: dev_bus_arbiter

Interface
REQ-001 Parameter: FIXED_PRI, default 0, 0 = round-robin between masters, 1 = master 0 (CPU) always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_req  input  1  master 0 (CPU) requests a device-bus access; held until m0_ready.
REQ-005 m0_addr  input  [31:2]  master 0 word address.
REQ-006 m0_wdata  input  32  master 0 write data.
REQ-007 m0_we  input  1  master 0 write enable (0 = read).
REQ-008 m0_be  input  4  master 0 byte enables.
REQ-009 m0_ready  output  1  one-cycle pulse, master 0 access complete.
REQ-010 m0_rdata  output  32  master 0 read data, valid while m0_ready=1.
REQ-011 m1_req, m1_addr, m1_wdata, m1_we, m1_be, m1_ready, m1_rdata: same directions, widths, meanings for master 1 (DMA/debug port).
REQ-012 bus_addr  output  [31:2]  address to device bridge.
REQ-013 bus_wdata  output  32  write data to bridge.
REQ-014 bus_we  output  1  write strobe to bridge.
REQ-015 bus_be  output  4  byte enables to bridge.
REQ-016 bus_rdata  input  32  combinational read data returned by bridge.
REQ-017 grant  output  2  one-hot owner of current access (01 = m0, 10 = m1, 00 = none).

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; exactly one access per grant.
REQ-019 IDLE: if any req=1 at edge, latch winner's addr/wdata/we/be into a request register, set grant, go to ACCESS; else stay IDLE.
REQ-020 Winner (FIXED_PRI=0): single requester wins; both requesting -> master other than last_owner wins.
REQ-021 Winner (FIXED_PRI=1): m0 wins whenever m0_req=1.
REQ-022 ACCESS (exactly 1 cycle): bus_addr/bus_wdata/bus_be/bus_we driven from request register; bus_rdata captured into rdata register at end of cycle; last_owner updated; go to RESP.
REQ-023 RESP (exactly 1 cycle): owner's ready=1, owner's rdata = captured value; bus_we=0; grant retains owner.
REQ-024 RESP exit: owner's req ignored this cycle; if the other master's req=1, latch it and go directly to ACCESS (back-to-back); else IDLE.
REQ-025 Latency: req sampled at edge N -> ACCESS in cycle N+1 -> ready in cycle N+2; min 3 cycles per access for one master, 2 cycles per access when alternating.
REQ-026 Outside ACCESS: bus_we=0, bus_be=4'h0, bus_addr=0, bus_wdata=0.
REQ-027 Non-owner ready=0 always; non-owner rdata=32'h0; owner rdata=0 when ready=0.
REQ-028 For write accesses, rdata is don't-care but shall still equal captured bus_rdata.
REQ-029 Request inputs changing during ACCESS/RESP do not affect the in-flight access.
REQ-030 Starvation bound (FIXED_PRI=0): a held req is granted within 2 accesses.

Reset
REQ-031 rst_n=0 (any time, incl. mid-access): state=IDLE, grant=00, m0_ready=m1_ready=0, rdata registers=0, request register=0, last_owner=m1 (so m0 wins first tie).
REQ-032 Aborted access never produces ready after reset release; a write in ACCESS when reset asserts is lost, no retry.

Structure
REQ-033 Shared package holds state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10) and owner constants OWN_M0/OWN_M1.
REQ-034 Single flat module; no sub-modules; winner selection is a combinational function.

Verification
REQ-035 Single read: m0_req, addr=30'h00001FC4 (0x7F10), bus_rdata=32'hA5A5_0001 -> bus_addr matches in cycle N+1, m0_ready=1 and m0_rdata=32'hA5A5_0001 in N+2, bus_we=0 throughout.
REQ-036 Single write: m1_req, we=1, be=4'hF, addr 0x7F20, wdata=32'h1234_5678 -> bus_we=1 for exactly one cycle with those values, m1_ready one cycle later.
REQ-037 Contention: both req held continuously from reset -> grant order m0,m1,m0,m1, ready alternates, back-to-back every 2 cycles.
REQ-038 FIXED_PRI=1, both req held -> m0 served every access, m1_ready never asserts while m0_req=1.
REQ-039 Reset during ACCESS of a write -> no ready pulse, bus_we=0 immediately, next req served as from clean reset.
REQ-040 Input change: m0_addr changed during ACCESS -> bus_addr keeps latched value; m0_req dropped during RESP -> no second access.

Source files
------------

// File: rtl/dev_bus_arbiter_pkg.sv
// dev_bus_arbiter_pkg: state encoding, owner constants, request record and winner selection
package dev_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10} state_t;
  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;
  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } req_t;
  // On a tie the master that did not own the previous access wins, unless fixed priority
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last, input logic fixed);
    return fixed ? (r0 ? OWN_M0 : OWN_M1) : (r0 && r1) ? ~last : (r0 ? OWN_M0 : OWN_M1);
  endfunction
endpackage

// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter: two-master arbiter for the device bus, one single-cycle access per grant
module dev_bus_arbiter
  import dev_bus_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:2] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:2] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic [31:2] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  grant
);
  localparam logic FIXED = (FIXED_PRI != 0);
  state_t      state, state_nx;
  logic        owner, owner_nx, last_owner, last_nx, win, other, other_req, handoff;
  req_t        rq, rq_nx, m0_rq, m1_rq;
  logic [31:0] rdata_q, rdata_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_M0;
      last_owner <= OWN_M1;
      rq         <= '0;
      rdata_q    <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_nx;
      rq         <= rq_nx;
      rdata_q    <= rdata_nx;
    end
  end
  assign m0_rq     = '{m0_addr, m0_wdata, m0_we, m0_be};
  assign m1_rq     = '{m1_addr, m1_wdata, m1_we, m1_be};
  assign win       = pick_winner(m0_req, m1_req, last_owner, FIXED);
  assign other     = ~owner;
  assign other_req = (owner == OWN_M0) ? m1_req : m0_req;
  // Under fixed priority a still-requesting CPU must not hand the bus to master 1
  assign handoff   = other_req && !(FIXED && owner == OWN_M0 && m0_req);
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_owner;
    rq_nx    = rq;
    rdata_nx = rdata_q;
    case (state)
      IDLE: if (m0_req || m1_req) begin
        state_nx = ACCESS;
        owner_nx = win;
        rq_nx    = (win == OWN_M1) ? m1_rq : m0_rq;
      end
      ACCESS: begin
        state_nx = RESP;
        rdata_nx = bus_rdata;
        last_nx  = owner;
      end
      RESP: if (handoff) begin
        state_nx = ACCESS;
        owner_nx = other;
        rq_nx    = (other == OWN_M1) ? m1_rq : m0_rq;
      end else begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus_addr  = (state == ACCESS) ? rq.addr  : '0;
  assign bus_wdata = (state == ACCESS) ? rq.wdata : '0;
  assign bus_we    = (state == ACCESS) && rq.we;
  assign bus_be    = (state == ACCESS) ? rq.be    : '0;
  assign grant     = (state == IDLE) ? 2'b00 : (owner == OWN_M1) ? 2'b10 : 2'b01;
  assign m0_ready  = (state == RESP) && (owner == OWN_M0);
  assign m1_ready  = (state == RESP) && (owner == OWN_M1);
  assign m0_rdata  = m0_ready ? rdata_q : '0;
  assign m1_rdata  = m1_ready ? rdata_q : '0;
endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb_dev_bus_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_dev_bus_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:2] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, bus_rdata = '0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic        m0_ready, m1_ready, bus_we, fp_m0_ready, fp_m1_ready, fp_bus_we;
  logic [31:0] m0_rdata, m1_rdata, bus_wdata, fp_m0_rdata, fp_m1_rdata, fp_bus_wdata;
  logic [31:2] bus_addr, fp_bus_addr;
  logic [3:0]  bus_be, fp_bus_be;
  logic [1:0]  grant, fp_grant;
  int checks = 0, errors = 0;
  logic [1:0] gx  [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
  logic [1:0] fgx [6] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
  logic       r0x [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       r1x [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       fr0x[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  dev_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_be(m0_be),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_be(m1_be),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .grant(grant)
  );
  dev_bus_arbiter #(.FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_be(m0_be),
    .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_be(m1_be),
    .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .bus_addr(fp_bus_addr), .bus_wdata(fp_bus_wdata), .bus_we(fp_bus_we), .bus_be(fp_bus_be),
    .bus_rdata(bus_rdata), .grant(fp_grant)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (2) step();
    rst_n = 1;
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'h0);
    chk("rst_m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
    chk("rst_bus_addr", {2'b0, bus_addr}, 32'h0);
    chk("rst_fp_grant", {30'b0, fp_grant}, 32'h0);
    m0_req = 1; m0_addr = 30'h1FC4; m0_we = 0; m0_be = 4'hF; bus_rdata = 32'hA5A5_0001;
    step();
    chk("rd_bus_addr", {2'b0, bus_addr}, 32'h0000_1FC4);
    chk("rd_grant_acc", {30'b0, grant}, 32'h1);
    chk("rd_we_acc", {31'b0, bus_we}, 32'h0);
    chk("rd_ready_acc", {31'b0, m0_ready}, 32'h0);
    step();
    bus_rdata = 32'h0;
    #1;
    chk("rd_ready", {31'b0, m0_ready}, 32'h1);
    chk("rd_rdata", m0_rdata, 32'hA5A5_0001);
    chk("rd_m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("rd_we_resp", {31'b0, bus_we}, 32'h0);
    chk("rd_grant_resp", {30'b0, grant}, 32'h1);
    chk("rd_addr_resp", {2'b0, bus_addr}, 32'h0);
    m0_req = 0;
    step();
    chk("rd_idle_grant", {30'b0, grant}, 32'h0);
    chk("rd_idle_ready", {31'b0, m0_ready}, 32'h0);
    chk("rd_idle_rdata", m0_rdata, 32'h0);
    m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 30'h1FC8; m1_wdata = 32'h1234_5678;
    bus_rdata = 32'hDEAD_BEEF;
    step();
    chk("wr_bus_we", {31'b0, bus_we}, 32'h1);
    chk("wr_bus_addr", {2'b0, bus_addr}, 32'h0000_1FC8);
    chk("wr_bus_wdata", bus_wdata, 32'h1234_5678);
    chk("wr_bus_be", {28'b0, bus_be}, 32'hF);
    chk("wr_grant", {30'b0, grant}, 32'h2);
    step();
    chk("wr_we_resp", {31'b0, bus_we}, 32'h0);
    chk("wr_be_resp", {28'b0, bus_be}, 32'h0);
    chk("wr_m1_ready", {31'b0, m1_ready}, 32'h1);
    chk("wr_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    chk("wr_m0_ready", {31'b0, m0_ready}, 32'h0);
    chk("wr_m0_rdata", m0_rdata, 32'h0);
    chk("wr_grant_resp", {30'b0, grant}, 32'h2);
    m1_req = 0; m1_we = 0;
    step();
    chk("wr_idle_ready", {31'b0, m1_ready}, 32'h0);
    chk("wr_idle_grant", {30'b0, grant}, 32'h0);
    m0_req = 1; m0_addr = 30'h100;
    step();
    m0_addr = 30'h200;
    #1;
    chk("chg_bus_addr", {2'b0, bus_addr}, 32'h100);
    step();
    chk("chg_ready", {31'b0, m0_ready}, 32'h1);
    m0_req = 0;
    step();
    chk("drop_grant1", {30'b0, grant}, 32'h0);
    step();
    chk("drop_grant2", {30'b0, grant}, 32'h0);
    chk("drop_ready", {31'b0, m0_ready}, 32'h0);
    rst_n = 0; #1; rst_n = 1;
    m0_addr = 30'h10; m1_addr = 30'h20; m0_req = 1; m1_req = 1;
    bus_rdata = 32'hC0DE_0000;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("ct_grant_%0d", i), {30'b0, grant}, {30'b0, gx[i-1]});
      chk($sformatf("ct_m0_ready_%0d", i), {31'b0, m0_ready}, {31'b0, r0x[i-1]});
      chk($sformatf("ct_m1_ready_%0d", i), {31'b0, m1_ready}, {31'b0, r1x[i-1]});
      chk($sformatf("ct_m0_rdata_%0d", i), m0_rdata, r0x[i-1] ? 32'hC0DE_0000 + i - 1 : 32'h0);
      chk($sformatf("ct_m1_rdata_%0d", i), m1_rdata, r1x[i-1] ? 32'hC0DE_0000 + i - 1 : 32'h0);
      if (i % 2 == 1)
        chk($sformatf("ct_bus_addr_%0d", i), {2'b0, bus_addr}, gx[i-1] == 2'b01 ? 32'h10 : 32'h20);
      chk($sformatf("fp_grant_%0d", i), {30'b0, fp_grant}, {30'b0, fgx[i-1]});
      chk($sformatf("fp_m0_ready_%0d", i), {31'b0, fp_m0_ready}, {31'b0, fr0x[i-1]});
      chk($sformatf("fp_m1_ready_%0d", i), {31'b0, fp_m1_ready}, 32'h0);
      chk($sformatf("fp_m0_rdata_%0d", i), fp_m0_rdata, fr0x[i-1] ? 32'hC0DE_0000 + i - 1 : 32'h0);
      bus_rdata = 32'hC0DE_0000 + i;
    end
    m0_req = 0; m1_req = 0;
    step();
    rst_n = 0; #1; rst_n = 1;
    m1_req = 1; m1_we = 1; m1_be = 4'h3; m1_wdata = 32'hCAFE_F00D; m1_addr = 30'h33;
    step();
    chk("ab_we_acc", {31'b0, bus_we}, 32'h1);
    chk("ab_addr_acc", {2'b0, bus_addr}, 32'h33);
    #2;
    rst_n = 0;
    #1;
    chk("ab_we_rst", {31'b0, bus_we}, 32'h0);
    chk("ab_grant_rst", {30'b0, grant}, 32'h0);
    chk("ab_addr_rst", {2'b0, bus_addr}, 32'h0);
    m1_req = 0; m1_we = 0;
    step();
    chk("ab_ready_held", {31'b0, m1_ready}, 32'h0);
    rst_n = 1;
    step();
    chk("ab_ready_rel", {31'b0, m1_ready}, 32'h0);
    chk("ab_grant_rel", {30'b0, grant}, 32'h0);
    m0_req = 1; m1_req = 1; m0_addr = 30'h44; m1_addr = 30'h55;
    step();
    chk("ab_tie_grant", {30'b0, grant}, 32'h1);
    chk("ab_tie_addr", {2'b0, bus_addr}, 32'h44);
    chk("ab_tie_we", {31'b0, bus_we}, 32'h0);
    step();
    chk("ab_tie_ready", {31'b0, m0_ready}, 32'h1);
    m0_req = 0; m1_req = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
